// File: rtl/layer2_pkg.sv
// Shared types and sign-magnitude helpers for the layer-2 neuron engine.
package layer2_pkg;
  localparam int SM_W   = 20;
  localparam int FRAC   = 18;
  localparam int MAG_W  = SM_W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int WIDE_W = 64;
  localparam logic [MAG_W-1:0] MAG_MAX = 19'h7FFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] idx;
  } tag_t;

  function automatic logic signed [PROD_W:0] sm2tc(input logic sign, input logic [PROD_W-1:0] mag);
    logic signed [PROD_W:0] v;
    v = $signed({1'b0, mag});
    return sign ? -v : v;
  endfunction

  // Round toward zero on the magnitude, saturate, and never emit negative zero.
  function automatic logic [SM_W-1:0] tc2sm(input logic signed [WIDE_W-1:0] v);
    logic [WIDE_W-1:0] m;
    logic [WIDE_W-1:0] sh;
    logic [MAG_W-1:0]  sat;
    m   = v[WIDE_W-1] ? WIDE_W'(-v) : WIDE_W'(v);
    sh  = m >> FRAC;
    sat = (sh > WIDE_W'(MAG_MAX)) ? MAG_MAX : sh[MAG_W-1:0];
    return {v[WIDE_W-1] && (sat != '0), sat};
  endfunction
endpackage

// File: rtl/layer2_mac_sm_mult.sv
// Stage 1: registered sign-magnitude multiply; the issue tag rides along.
module sm_mult
  import layer2_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  tag_t              tag,
  input  logic [SM_W-1:0]   w,
  input  logic [SM_W-1:0]   a,
  output logic              vld_q,
  output tag_t              tag_q,
  output logic              sign_q,
  output logic [PROD_W-1:0] mag_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      sign_q <= 1'b0;
      mag_q  <= '0;
    end else begin
      vld_q <= vld;
      if (vld) begin
        tag_q  <= tag;
        sign_q <= w[SM_W-1] ^ a[SM_W-1];
        mag_q  <= PROD_W'(w[MAG_W-1:0]) * PROD_W'(a[MAG_W-1:0]);
      end
    end
  end
endmodule

// File: rtl/layer2_mac.sv
// Layer-2 neuron engine: address sweep, 2-stage MAC, saturated SM result per neuron.
// Define LAYER2_RELU_EN to clamp negative results to zero.
module layer2_mac
  import layer2_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int N_OUT = 3,
  parameter int ACC_W = 44
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [7:0]      w_addr,
  input  logic [SM_W-1:0] w_data,
  output logic [7:0]      a_addr,
  input  logic [SM_W-1:0] a_data,
  output logic            busy,
  output logic            out_valid,
  output logic [7:0]      out_idx,
  output logic [SM_W-1:0] out_data,
  output logic            done
);
  localparam int TOTAL = N_IN * N_OUT;

  state_t     state;
  logic       drain_cnt;
  logic [7:0] n_cnt;
  logic [1:0] vld_pipe;
  tag_t       issue_tag, s1_tag;
  logic       p_sign;
  logic [PROD_W-1:0] p_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_addr    <= '0;
      a_addr    <= '0;
      n_cnt     <= '0;
      busy      <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= RUN;
          busy   <= 1'b1;
          w_addr <= '0;
          a_addr <= '0;
          n_cnt  <= '0;
        end
        RUN: if (w_addr == 8'(TOTAL - 1)) begin
          state     <= DRAIN;
          drain_cnt <= 1'b0;
          w_addr    <= '0;
          a_addr    <= '0;
          n_cnt     <= '0;
        end else begin
          w_addr <= w_addr + 8'd1;
          if (a_addr == 8'(N_IN - 1)) begin
            a_addr <= '0;
            n_cnt  <= n_cnt + 8'd1;
          end else begin
            a_addr <= a_addr + 8'd1;
          end
        end
        DRAIN: if (drain_cnt) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          drain_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vld_pipe[0]     = (state == RUN);
  assign issue_tag.first = (a_addr == '0);
  assign issue_tag.last  = (a_addr == 8'(N_IN - 1));
  assign issue_tag.idx   = n_cnt;

  sm_mult u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld    (vld_pipe[0]),
    .tag    (issue_tag),
    .w      (w_data),
    .a      (a_data),
    .vld_q  (vld_pipe[1]),
    .tag_q  (s1_tag),
    .sign_q (p_sign),
    .mag_q  (p_mag)
  );

  logic signed [PROD_W:0]  p_tc;
  logic signed [ACC_W-1:0] p_ext, acc, acc_next;
  logic [SM_W-1:0]         res_sm, res;

  assign p_tc     = sm2tc(p_sign, p_mag);
  assign p_ext    = ACC_W'(p_tc);
  assign acc_next = s1_tag.first ? p_ext : acc + p_ext;
  assign res_sm   = tc2sm(WIDE_W'(acc_next));

`ifdef LAYER2_RELU_EN
  assign res = res_sm[SM_W-1] ? '0 : res_sm;
`else
  assign res = res_sm;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= vld_pipe[1] & s1_tag.last;
      done      <= vld_pipe[1] & s1_tag.last & (s1_tag.idx == 8'(N_OUT - 1));
      if (vld_pipe[1]) acc <= acc_next;
      if (vld_pipe[1] && s1_tag.last) begin
        out_idx  <= s1_tag.idx;
        out_data <= res;
      end
    end
  end
endmodule

// File: tb/tb_layer2_mac.sv
// Self-checking bench for layer2_mac: per-cycle checks against a dot-product reference model.
module tb_layer2_mac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  w_addr, a_addr, out_idx;
  logic [19:0] w_data, a_data, out_data;
  logic        busy, out_valid, done;

  logic [19:0] rom [0:255];
  logic [19:0] act [0:4];
  int          start_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign w_data = rom[w_addr];
  assign a_data = act[a_addr];

  layer2_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .w_addr(w_addr), .w_data(w_data), .a_addr(a_addr), .a_data(a_data),
    .busy(busy), .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .done(done)
  );

  // Q1.18 dot product, truncated toward zero, saturated, sign-magnitude.
  function automatic logic [19:0] ref_neuron(input int n);
    longint sum, p, m;
    logic [19:0] w, a;
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      w = rom[n*5 + i];
      a = act[i];
      p = longint'(w[18:0]) * longint'(a[18:0]);
      sum += (w[19] ^ a[19]) ? -p : p;
    end
    m = ((sum < 0) ? -sum : sum) / 262144;
    if (m > 524287) m = 524287;
    if (m == 0) return 20'h0;
    if (sum < 0) begin
`ifdef LAYER2_RELU_EN
      return 20'h0;
`else
      return {1'b1, m[18:0]};
`endif
    end
    return {1'b0, m[18:0]};
  endfunction

  task automatic fill_rom_random();
    for (int k = 0; k < 256; k++) rom[k] = 20'($urandom);
  endtask

  task automatic set_acts(input logic [19:0] v);
    for (int i = 0; i < 5; i++) act[i] = v;
  endtask

  // Drives the starts in start_q for ncyc cycles and checks every cycle.
  task automatic run_seq(input string name, input int ncyc);
    logic [19:0] r [3];
    bit   eb [64];
    bit   ev [64];
    bit   ed [64];
    int   ek [64];
    int   ei [64];
    logic [19:0] edat [64];
    int   last_acc;
    bit   st;
    for (int n = 0; n < 3; n++) r[n] = ref_neuron(n);
    for (int c = 0; c < 64; c++) begin
      eb[c] = 0; ev[c] = 0; ed[c] = 0; ek[c] = -1; ei[c] = 0; edat[c] = '0;
    end
    last_acc = -100;
    foreach (start_q[q]) begin
      if (start_q[q] >= last_acc + 18) begin
        last_acc = start_q[q];
        for (int c = last_acc + 1; c <= last_acc + 17; c++) begin
          eb[c] = 1;
          if (c - last_acc - 1 < 15) ek[c] = c - last_acc - 1;
        end
        for (int j = 0; j < 3; j++) begin
          ev[last_acc + 7 + 5*j] = 1;
          ei[last_acc + 7 + 5*j] = j;
          edat[last_acc + 7 + 5*j] = r[j];
        end
        ed[last_acc + 17] = 1;
      end
    end
    for (int c = 0; c < ncyc; c++) begin
      st = 0;
      foreach (start_q[q]) if (start_q[q] == c) st = 1;
      start = st;
      @(negedge clk);
      n_cmp++;
      if (busy !== eb[c]) begin n_bad++; $display("FAIL %s busy c%0d: got %b want %b", name, c, busy, eb[c]); end
      n_cmp++;
      if (out_valid !== ev[c]) begin n_bad++; $display("FAIL %s out_valid c%0d: got %b want %b", name, c, out_valid, ev[c]); end
      n_cmp++;
      if (done !== ed[c]) begin n_bad++; $display("FAIL %s done c%0d: got %b want %b", name, c, done, ed[c]); end
      if (ev[c]) begin
        n_cmp++;
        if (out_idx !== 8'(ei[c]) || out_data !== edat[c]) begin
          n_bad++;
          $display("FAIL %s result c%0d: got idx %0d data %h want idx %0d data %h", name, c, out_idx, out_data, ei[c], edat[c]);
        end
      end
      if (ek[c] >= 0) begin
        n_cmp++;
        if (w_addr !== 8'(ek[c]) || a_addr !== 8'(ek[c] % 5)) begin
          n_bad++;
          $display("FAIL %s addr c%0d: got w %0d a %0d want w %0d a %0d", name, c, w_addr, a_addr, ek[c], ek[c] % 5);
        end
      end
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  task automatic check_all_zero(input string name, input int c);
    n_cmp++;
    if ({w_addr, a_addr, out_idx, out_data, busy, out_valid, done} !== '0) begin
      n_bad++;
      $display("FAIL %s zero c%0d: got w %h a %h idx %h data %h busy %b v %b d %b want all 0",
               name, c, w_addr, a_addr, out_idx, out_data, busy, out_valid, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    check_all_zero("reset", 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check_all_zero("after_release", 0);
  endtask

  task automatic test_unity_acts();
    fill_rom_random();
    set_acts(20'h40000);
    start_q = {0};
    run_seq("unity", 22);
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      fill_rom_random();
      for (int i = 0; i < 5; i++) act[i] = 20'($urandom);
      start_q = {0, 18 + int'($urandom_range(0, 3))};
      run_seq("random", 44);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 15; k++) rom[k] = (k / 5 == 1) ? 20'hFFFFF : 20'h7FFFF;
    set_acts(20'h7FFFF);
    start_q = {0};
    run_seq("saturate", 20);
  endtask

  task automatic test_zero_acts();
    fill_rom_random();
    set_acts(20'h00000);
    start_q = {0};
    run_seq("zero", 20);
    set_acts(20'h80000);
    start_q = {0};
    run_seq("neg_zero", 20);
  endtask

  task automatic test_back_to_back();
    fill_rom_random();
    set_acts(20'h40000);
    act[2] = 20'hC0000;
    start_q = {0, 5, 17, 18};
    run_seq("back_to_back", 40);
  endtask

  task automatic test_reset_mid_run();
    fill_rom_random();
    set_acts(20'h40000);
    for (int c = 0; c < 40; c++) begin
      start = (c == 0);
      if (c == 9) rst_n = 0;
      if (c == 11) rst_n = 1;
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst busy c%0d: got %b want 1", c, busy); end
      end
      if (c >= 9) check_all_zero("midrst", c);
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  initial begin
    set_acts(20'h0);
    fill_rom_random();
    test_reset();
    test_unity_acts();
    test_random();
    test_saturate();
    test_zero_acts();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
